// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types, widths and helpers for the configurable Huffman decoder
package huffman_pkg;
    localparam int DEF_IN_W         = 32;
    localparam int DEF_SYM_W        = 4;
    localparam int DEF_MAX_CODE_LEN = 6;
    localparam int LEN_W            = $clog2(DEF_MAX_CODE_LEN + 1);
    localparam int NB_W             = $clog2(DEF_IN_W);

    typedef struct packed {
        logic [LEN_W-1:0]            len;
        logic [DEF_MAX_CODE_LEN-1:0] code;
        logic [DEF_SYM_W-1:0]        sym;
    } entry_t;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERROR} state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_INVALID = 2'd1;
    localparam logic [1:0] ERR_TRAIL   = 2'd2;

    function automatic logic [DEF_MAX_CODE_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
        for (int j = 0; j < DEF_MAX_CODE_LEN; j++) len_mask[j] = LEN_W'(j) < l;
    endfunction
endpackage

// File: rtl/huffman_match_lut.sv
// huffman_match_lut: priority matcher of buffered stream bits against the code table
module huffman_match_lut
    import huffman_pkg::*;
#(
    parameter int NUM_SYM = 2 ** DEF_SYM_W
) (
    input  entry_t                      tbl [NUM_SYM],
    input  logic [DEF_MAX_CODE_LEN-1:0] bits,
    input  logic [LEN_W-1:0]            avail,
    output logic                        match,
    output logic [LEN_W-1:0]            len,
    output logic [DEF_SYM_W-1:0]        sym
);
    // scan from the top so the lowest matching index is the one left standing
    always_comb begin
        match = 1'b0;
        len   = '0;
        sym   = '0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if (tbl[i].len != '0 && tbl[i].len <= avail &&
                ((bits ^ tbl[i].code) & len_mask(tbl[i].len)) == '0) begin
                match = 1'b1;
                len   = tbl[i].len;
                sym   = tbl[i].sym;
            end
        end
    end
endmodule

// File: rtl/huffman_decoder_cfg.sv
// huffman_decoder_cfg: table-programmable Huffman bitstream decoder with backpressure and drain
module huffman_decoder_cfg
    import huffman_pkg::*;
#(
    parameter int IN_W         = DEF_IN_W,
    parameter int SYM_W        = DEF_SYM_W,
    parameter int MAX_CODE_LEN = DEF_MAX_CODE_LEN,
    parameter int BUF_W        = 64,
    parameter int CNT_W        = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              cfg_we,
    input  logic [SYM_W-1:0]                  cfg_idx,
    input  logic [$clog2(MAX_CODE_LEN+1)-1:0] cfg_len,
    input  logic [MAX_CODE_LEN-1:0]           cfg_code,
    input  logic [SYM_W-1:0]                  cfg_sym,
    input  logic [IN_W-1:0]                   in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    input  logic [$clog2(IN_W)-1:0]           in_nbits,
    output logic                              in_ready,
    output logic [SYM_W-1:0]                  out_sym,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CNT_W-1:0]                  sym_count,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [1:0]                        err_code
);
    localparam int CW      = $clog2(BUF_W + 1);
    localparam int LW      = $clog2(MAX_CODE_LEN + 1);
    localparam int NUM_SYM = 2 ** SYM_W;

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CW-1:0]     cnt_q, cnt_d, consumed, remaining, nb;
    entry_t            tbl_q [NUM_SYM];
    logic [SYM_W-1:0]  out_sym_q, m_sym;
    logic              out_valid_q, err_q, match, fire, accept, clr, err_set;
    logic [CNT_W-1:0]  sym_count_q;
    logic [1:0]        err_code_q, err_val;
    logic [LW-1:0]     m_len, avail;
    logic [IN_W-1:0]   rev;

    huffman_match_lut #(.NUM_SYM(NUM_SYM)) u_lut (
        .tbl   (tbl_q),
        .bits  (buf_q[MAX_CODE_LEN-1:0]),
        .avail (avail),
        .match (match),
        .len   (m_len),
        .sym   (m_sym)
    );

    assign avail     = (cnt_q >= CW'(MAX_CODE_LEN)) ? LW'(MAX_CODE_LEN) : LW'(cnt_q);
    assign in_ready  = state_q == S_RUN && cnt_q <= CW'(BUF_W - IN_W);
    assign accept    = in_ready && in_valid;
    assign fire      = match && (state_q == S_RUN || state_q == S_DRAIN) && (!out_valid_q || out_ready);
    assign consumed  = fire ? CW'(m_len) : '0;
    assign remaining = cnt_q - consumed;
    assign nb        = (in_last && in_nbits != '0) ? CW'(in_nbits) : CW'(IN_W);
    assign clr       = start && !abort && (state_q == S_IDLE || state_q == S_ERROR);
    assign buf_d     = (abort || clr) ? '0 : (buf_q >> consumed) | (accept ? BUF_W'(rev) << remaining : '0);
    assign cnt_d     = (abort || clr) ? '0 : remaining + (accept ? nb : '0);

    assign out_sym   = out_sym_q;
    assign out_valid = out_valid_q;
    assign sym_count = sym_count_q;
    assign busy      = state_q == S_RUN || state_q == S_DRAIN;
    assign done      = state_q == S_DONE;
    assign err       = err_q;
    assign err_code  = err_code_q;

    // bit-reverse the word so stream bit k lands at buffer bit k; bits past the valid count are zeroed
    always_comb begin
        rev = '0;
        for (int k = 0; k < IN_W; k++) rev[k] = in_data[IN_W-1-k] & (CW'(k) < nb);
    end

    // next-state logic; abort overrides everything and keeps the error flag
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        err_val = ERR_NONE;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (!match && cnt_q >= CW'(MAX_CODE_LEN)) begin
                    state_d = S_ERROR;
                    err_set = 1'b1;
                    err_val = ERR_INVALID;
                end else if (accept && in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == '0 && !out_valid_q) state_d = S_DONE;
                else if (!match && cnt_q != '0) begin
                    state_d = S_ERROR;
                    err_set = 1'b1;
                    err_val = ERR_TRAIL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            err_set = 1'b0;
        end
    end

    // sequencing, bit buffer, output register and status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            out_sym_q   <= '0;
            out_valid_q <= 1'b0;
            sym_count_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= abort ? 1'b0 : fire ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
            if (fire) out_sym_q <= m_sym;
            sym_count_q <= clr ? '0 : (fire && sym_count_q != '1) ? sym_count_q + CNT_W'(1) : sym_count_q;
            err_q       <= clr ? 1'b0 : err_set ? 1'b1 : err_q;
            err_code_q  <= clr ? ERR_NONE : err_set ? err_val : err_code_q;
        end
    end

    // code table, writable only while idle and wiped by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SYM; i++) tbl_q[i] <= '0;
        end else if (state_q == S_IDLE && cfg_we) begin
            tbl_q[cfg_idx] <= {cfg_len, cfg_code, cfg_sym};
        end
    end
endmodule

// File: tb/tb_huffman_decoder_cfg.sv
// tb_huffman_decoder_cfg: directed self-checking bench for the configurable Huffman decoder
module tb_huffman_decoder_cfg;
    logic        clk = 1'b0;
    logic        reset_n, start, abort, cfg_we, in_valid, in_last, out_ready;
    logic [3:0]  cfg_idx, cfg_sym, out_sym;
    logic [2:0]  cfg_len;
    logic [5:0]  cfg_code;
    logic [31:0] in_data;
    logic [4:0]  in_nbits;
    logic        in_ready, out_valid, busy, done, err;
    logic [15:0] sym_count;
    logic [1:0]  err_code;

    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    bit streaming = 0;
    bit stall_seen = 0;
    logic [3:0] got[$];
    logic [3:0] syms[$];
    bit bq[$];
    int lens[16]  = '{2, 3, 4, 5, 5, 6, 6, 4, 0, 5, 6, 6, 5, 4, 3, 3};
    int codes[16] = '{'b00, 'b110, 'b1110, 'b10010, 'b01100, 'b111100, 'b011010, 'b1000,
                      0, 'b11111, 'b011011, 'b111101, 'b10011, 'b0111, 'b010, 'b101};
    logic [3:0] exp4[4] = '{4'h0, 4'h1, 4'hE, 4'hF};

    huffman_decoder_cfg dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_len(cfg_len), .cfg_code(cfg_code), .cfg_sym(cfg_sym),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_nbits(in_nbits), .in_ready(in_ready),
        .out_sym(out_sym), .out_valid(out_valid), .out_ready(out_ready),
        .sym_count(sym_count), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // record output transfers and done pulses between clock edges
    always @(negedge clk) begin
        if (out_valid && out_ready) got.push_back(out_sym);
        if (done) done_cnt++;
        if (streaming && in_valid && !in_ready) stall_seen = 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int i, input int l);
        cfg_idx  = 4'(i);
        cfg_len  = 3'(l);
        cfg_sym  = 4'(i);
        cfg_code = '0;
        for (int j = 0; j < l; j++) cfg_code[j] = codes[i][l-1-j];
        cfg_we = 1;
        tick();
        cfg_we = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [4:0] nb);
        in_data  = d;
        in_last  = last;
        in_nbits = nb;
        in_valid = 1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("in_accept", in_ready, 1);
        tick();
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(tag, done, 1);
        tick();
    endtask

    task automatic wait_err(input string tag);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (err) break;
        end
        chk(tag, err, 1);
        tick();
    endtask

    task automatic wait_got(input int n);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (got.size() >= n) break;
        end
        chk("wait_syms", got.size() >= n, 1);
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic pulse_abort();
        abort = 1;
        tick();
        abort = 0;
    endtask

    initial begin
        logic [31:0] w;
        int nw, nbl;
        reset_n = 0; start = 0; abort = 0; cfg_we = 0; cfg_idx = 0; cfg_len = 0; cfg_code = 0; cfg_sym = 0;
        in_data = 0; in_valid = 0; in_last = 0; in_nbits = 0; out_ready = 1;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sym", out_sym, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_sym_count", sym_count, 0);
        reset_n = 1;
        tick();
        for (int i = 0; i < 16; i++) if (i != 8) load_entry(i, lens[i]);

        got.delete(); done_cnt = 0;
        pulse_start();
        chk("basic_busy", busy, 1);
        send_word(32'h32A00000, 1, 5'd11);
        wait_done("basic_done", 50);
        chk("basic_n", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("basic_sym", got[i], exp4[i]);
        chk("basic_count", sym_count, 4);
        tick(); tick();
        chk("basic_done_once", done_cnt, 1);
        chk("basic_idle", busy, 0);

        got.delete(); out_ready = 0;
        pulse_start();
        send_word(32'h32A00000, 1, 5'd11);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_sym", out_sym, 0);
            @(negedge clk);
        end
        tick();
        out_ready = 1;
        wait_done("bp_done", 50);
        chk("bp_n", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_sym", got[i], exp4[i]);
        chk("bp_count", sym_count, 4);

        got.delete(); syms.delete(); bq.delete();
        while (bq.size() < 1025) begin
            int s;
            s = $urandom_range(0, 14);
            if (s >= 8) s++;
            syms.push_back(4'(s));
            for (int j = 0; j < lens[s]; j++) bq.push_back(codes[s][lens[s]-1-j]);
        end
        nw  = (bq.size() + 31) / 32;
        nbl = bq.size() % 32;
        while (bq.size() < nw * 32) bq.push_back(0);
        pulse_start();
        streaming = 1;
        for (int wi = 0; wi < nw; wi++) begin
            for (int j = 0; j < 32; j++) w[31-j] = bq[wi*32+j];
            send_word(w, wi == nw - 1, 5'(nbl));
        end
        streaming = 0;
        wait_done("stream_done", 2000);
        chk("stream_n", got.size(), syms.size());
        for (int i = 0; i < syms.size(); i++) chk("stream_sym", got[i], syms[i]);
        chk("stream_count", sym_count, syms.size());
        chk("stream_stall", stall_seen, 1);

        got.delete();
        pulse_start();
        send_word(32'h32A00000, 0, 5'd0);
        wait_got(2);
        tick();
        pulse_abort();
        chk("abort_idle", {busy, in_ready, out_valid}, 0);
        got.delete(); done_cnt = 0;
        pulse_start();
        send_word(32'h32A00000, 1, 5'd11);
        wait_done("abort_fresh_done", 50);
        chk("abort_fresh_n", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("abort_fresh_sym", got[i], exp4[i]);

        got.delete();
        pulse_start();
        send_word(32'h00000000, 1, 5'd0);
        wait_got(3);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out", {out_valid, out_sym}, 0);
        chk("mid_rst_status", {busy, done, err, err_code}, 0);
        chk("mid_rst_count", sym_count, 0);
        tick();
        reset_n = 1;
        tick();
        pulse_start();
        send_word(32'h00000000, 0, 5'd0);
        wait_err("table_lost_err");
        chk("table_lost_code", err_code, 1);
        pulse_abort();
        chk("abort_keeps_err", {busy, err}, 2'b01);
        for (int i = 0; i < 16; i++) load_entry(i, (i == 0 || i == 8) ? 0 : lens[i]);

        got.delete();
        pulse_start();
        chk("inv_err_cleared", err, 0);
        send_word(32'h00000000, 0, 5'd0);
        wait_err("inv_err");
        chk("inv_code", err_code, 1);
        chk("inv_state_error", busy, 0);
        chk("inv_no_out", got.size(), 0);

        done_cnt = 0;
        pulse_start();
        chk("trail_err_cleared", {err, err_code}, 0);
        send_word(32'h80000000, 1, 5'd1);
        wait_err("trail_err");
        chk("trail_code", err_code, 2);
        chk("trail_no_done", done_cnt, 0);
        chk("trail_state_error", busy, 0);
        pulse_abort();
        chk("trail_abort_keeps", {busy, err, err_code}, 4'b0110);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/huffman_decoder_cfg.md
Name:
huffman_decoder_cfg

Overview:
- Parametrised, table-programmable Huffman bitstream decoder.
- Sits between the compressed-weight SRAM read port (D_xmem) and the L0/compute path.
- Unpacks IN_W-bit compressed words into SYM_W-bit symbols through a sliding bit buffer.
- Adds over the fixed-table generation: runtime-loadable code table, output backpressure, end-of-stream drain with partial final word, and invalid-code/trailing-bit error detection.

Parameters:
- IN_W, 32: compressed input word width.
- SYM_W, 4: decoded symbol width; table holds NUM_SYM = 2**SYM_W entries.
- MAX_CODE_LEN, 6: longest code length in bits; legal range 1..16.
- BUF_W, 64: bit-buffer depth; must satisfy BUF_W >= IN_W + MAX_CODE_LEN - 1.
- CNT_W, 16: width of the decoded-symbol counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse, IDLE -> RUN; clears buffer, counter and error.
- abort  in  1  pulse; any state -> IDLE; buffer cleared.
- cfg_we  in  1  table write strobe; honoured in IDLE only.
- cfg_idx  in  SYM_W  table entry index.
- cfg_len  in  clog2(MAX_CODE_LEN+1)  code length; 0 disables the entry.
- cfg_code  in  MAX_CODE_LEN  code bits, stream order: first stream bit in bit 0.
- cfg_sym  in  SYM_W  symbol emitted on match.
- in_data  in  IN_W  compressed word; first stream bit is the MSB.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final word of the stream.
- in_nbits  in  clog2(IN_W)  valid bits in the last word, taken from the MSB down; 0 means IN_W.
- in_ready  out  1  decoder accepts a word this cycle.
- out_sym  out  SYM_W  decoded symbol.
- out_valid  out  1  out_sym valid; held until out_ready.
- out_ready  in  1  consumer accepts out_sym.
- sym_count  out  CNT_W  symbols emitted since start; saturates at all-ones.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  one-cycle pulse on stream completion.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 invalid code, 2 trailing bits.

Behaviour:
- Reset: state IDLE; buffer, count, table (all entries disabled), sym_count cleared. Outputs in_ready=0, out_valid=0, out_sym=0, busy=0, done=0, err=0, err_code=0.
- Reset asserted mid-stream aborts immediately with the same values; the table is lost.
- States:
  - IDLE: start -> RUN.
  - RUN: accepting a word with in_last=1 -> DRAIN.
  - DRAIN: count==0 and out_valid==0 -> DONE; no match with count>0 -> ERROR(code 2).
  - DONE: one cycle, done=1 -> IDLE.
  - ERROR: holds err and err_code; start -> RUN with err cleared.
  - abort: any state -> IDLE; err is kept.
- Buffer: stream bit k is held at buffer[k]. The input word is bit-reversed before insertion.
- Match rules:
  - Entry i matches when len_i != 0, len_i <= count, and buffer[len_i-1:0] == code_i[len_i-1:0].
  - If several entries match, the lowest index wins.
  - fire = match && state in {RUN, DRAIN} && (!out_valid || out_ready).
- On fire:
  - out_sym <= sym of the winning entry; out_valid <= 1.
  - buffer shifts right by len; count -= len.
  - sym_count increments.
- Output handshake: out_ready && out_valid with no fire clears out_valid. out_sym and out_valid are stable while out_valid && !out_ready.
- in_ready = (state==RUN) && (count <= BUF_W - IN_W); combinational from registered state.
- On input accept, the new bits are appended at bit position (count - consumed) in the same cycle, with consumed = len on fire and 0 otherwise. count_next = count - consumed + nbits, where nbits = IN_W, or in_nbits when in_last is set. Bits above the valid bits are written as 0.
- Throughput: one symbol per cycle; one word per cycle while the buffer has room. Symbol latency is one cycle after the last bit of its code is in the buffer.
- Invalid code: in RUN, no match with count >= MAX_CODE_LEN -> ERROR(code 1). The offending bits are not consumed.
- Disabled-entry codes are never matched.
- cfg_we outside IDLE is ignored.
- count never exceeds BUF_W; guaranteed by the in_ready rule.

Decomposition:
- Package huffman_pkg holds:
  - the table-entry typedef {len, code, sym};
  - the state enum (IDLE, RUN, DRAIN, DONE, ERROR);
  - err_code constants;
  - the clog2-derived width constants.
- Sub-module huffman_match_lut: combinational; inputs are the table and the buffer LSBs, outputs are {match, len, sym}. It keeps the priority matcher apart from the sequencing/buffer logic.

Test Plan:
- Basic decode: load the 15-entry table (0:00, 1:110, E:010, F:101, 2:1110, 7:1000, D:0111, 3:10010, 4:01100, 9:11111, C:10011, 5:111100, 6:011010, A:011011, B:111101). Then start; in_data=0x32A00000, in_last=1, in_nbits=11 -> out_sym 0,1,E,F on consecutive cycles; sym_count=4; done pulse; back to IDLE.
- Backpressure: same stream with out_ready low for 5 cycles after the first out_valid -> out_sym=0 held stable for those cycles; order and count unchanged; no symbol lost.
- Streaming: 32 back-to-back random words encoded with the table, then a final partial word -> decoded sequence equals the golden model; in_ready drops whenever count > 32; no overflow.
- Invalid code: disable the entry for symbol 0 (cfg_len=0); send 0x00000000 -> err=1, err_code=1; state ERROR; no out_valid.
- Trailing bits: last word 0x80000000 with in_nbits=1 -> DRAIN, then err_code=2; no done pulse.
- Reset/abort mid-stream: assert reset_n=0 after 3 symbols -> all outputs at reset values immediately. Separately, abort -> IDLE with the buffer empty; a subsequent start decodes a fresh stream correctly.
